// File: rtl/crc_serial_engine.sv
// crc_serial_engine: multi-cycle CRC generator/checker, MSB first, BITS_PER_CLK bits per cycle
module crc_serial_engine #(
  parameter int DATA_W = 32,
  parameter int CRC_W = 4,
  parameter logic [CRC_W-1:0] POLY = 'h3,
  parameter logic [CRC_W-1:0] INIT = '0,
  parameter int BITS_PER_CLK = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [DATA_W-1:0]       D_IN,
  input  logic [CRC_W-1:0]        CRC_IN,
  input  logic                    CHK,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [DATA_W+CRC_W-1:0] D_OUT,
  output logic                    CRC_ERR,
  output logic                    BUSY
);
  localparam int N = DATA_W / BITS_PER_CLK;
  localparam int CNT_W = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d, work_q, work_d;
  logic [CRC_W-1:0] r_q, r_d, crc_in_q, crc_in_d, r_step;
  logic chk_q, chk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // BITS_PER_CLK chained single-bit division steps
  always_comb begin
    r_step = r_q;
    for (int i = 0; i < BITS_PER_CLK; i++)
      r_step = {r_step[CRC_W-2:0], 1'b0} ^ ((r_step[CRC_W-1] ^ work_q[DATA_W-1-i]) ? POLY : '0);
  end
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    work_d = work_q;
    r_d = r_q;
    crc_in_d = crc_in_q;
    chk_d = chk_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && IN_VALID) begin
      state_d = CALC;
      data_d = D_IN;
      work_d = D_IN;
      crc_in_d = CRC_IN;
      chk_d = CHK;
      r_d = INIT;
      cnt_d = '0;
    end
    if (state_q == CALC) begin
      r_d = r_step;
      work_d = work_q << BITS_PER_CLK;
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CNT_W'(N - 1) ? DONE : CALC;
    end
    if (state_q == DONE && OUT_READY) state_d = IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      data_q <= '0;
      work_q <= '0;
      r_q <= INIT;
      crc_in_q <= '0;
      chk_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      work_q <= work_d;
      r_q <= r_d;
      crc_in_q <= crc_in_d;
      chk_q <= chk_d;
      cnt_q <= cnt_d;
    end
  end
  assign BUSY = state_q != IDLE;
  assign IN_READY = state_q == IDLE;
  assign OUT_VALID = state_q == DONE;
  assign D_OUT = OUT_VALID ? {data_q, r_q} : '0;
  assign CRC_ERR = OUT_VALID && chk_q && (r_q != crc_in_q);
endmodule

// File: tb/tb_crc_serial_engine.sv
// tb_crc_serial_engine: scoreboard bench for BITS_PER_CLK = 1, 4 and 32 instances
module tb_crc_serial_engine;
  localparam int BPC [3] = '{1, 4, 32};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] in_valid = '0, out_ready = '0, chk = '0;
  logic [2:0] in_ready, out_valid, crc_err, busy;
  logic [2:0][31:0] d_in = '0;
  logic [2:0][3:0] crc_in = '0;
  logic [2:0][35:0] d_out;
  logic [36:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    crc_serial_engine #(.BITS_PER_CLK(BPC[g])) u_dut (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid[g]), .IN_READY(in_ready[g]),
      .D_IN(d_in[g]), .CRC_IN(crc_in[g]), .CHK(chk[g]), .OUT_VALID(out_valid[g]),
      .OUT_READY(out_ready[g]), .D_OUT(d_out[g]), .CRC_ERR(crc_err[g]), .BUSY(busy[g])
    );
  end
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] crc_ref(input logic [31:0] d);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 31; i >= 0; i--) r = {r[2:0], 1'b0} ^ ((r[3] ^ d[i]) ? 4'h3 : 4'h0);
    return r;
  endfunction
  task automatic check_idle(input int k);
    check("idle_in_ready", 64'(in_ready[k]), 64'(1));
    check("idle_busy", 64'(busy[k]), 64'(0));
    check("idle_out_valid", 64'(out_valid[k]), 64'(0));
    check("idle_d_out", 64'(d_out[k]), 64'(0));
    check("idle_crc_err", 64'(crc_err[k]), 64'(0));
  endtask
  task automatic xact(input int k, input logic [31:0] d, input logic c, input logic [3:0] ci,
                      input logic [3:0] ecrc, input logic eerr, input int stall);
    int lat;
    logic [36:0] e;
    exp_q.push_back({d, ecrc, eerr});
    check("accept_ready", 64'(in_ready[k]), 64'(1));
    in_valid[k] = 1'b1;
    d_in[k] = d;
    chk[k] = c;
    crc_in[k] = ci;
    tick();
    in_valid[k] = 1'b0;
    d_in[k] = $urandom;
    crc_in[k] = 4'($urandom);
    chk[k] = ~c;
    lat = 0;
    while (!out_valid[k] && lat < 64) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(32 / BPC[k]));
    check("sb_depth", 64'(exp_q.size()), 64'(1));
    e = exp_q.pop_front();
    check("d_out", 64'(d_out[k]), 64'(e[36:1]));
    check("crc_err", 64'(crc_err[k]), 64'(e[0]));
    for (int i = 0; i < stall; i++) begin
      in_valid[k] = 1'b1;
      tick();
      check("hold_d_out", 64'(d_out[k]), 64'(e[36:1]));
      check("hold_crc_err", 64'(crc_err[k]), 64'(e[0]));
      check("hold_out_valid", 64'(out_valid[k]), 64'(1));
      check("hold_in_ready", 64'(in_ready[k]), 64'(0));
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    check_idle(k);
  endtask
  initial begin
    tick();
    for (int k = 0; k < 3; k++) check_idle(k);
    rst = 1'b0;
    tick();
    xact(0, 32'h0000_0001, 1'b0, 4'h0, 4'h3, 1'b0, 0);
    xact(0, 32'h0000_0000, 1'b0, 4'h0, 4'h0, 1'b0, 0);
    xact(0, 32'h8000_0000, 1'b0, 4'h0, 4'h6, 1'b0, 0);
    xact(0, 32'hFFFF_FFFF, 1'b0, 4'h0, 4'h5, 1'b0, 0);
    xact(0, 32'h8000_0000, 1'b1, 4'h6, 4'h6, 1'b0, 0);
    xact(0, 32'h8000_0000, 1'b1, 4'h7, 4'h6, 1'b1, 0);
    xact(0, 32'h0000_0001, 1'b0, 4'h7, 4'h3, 1'b0, 0);
    xact(0, 32'h8000_0000, 1'b0, 4'h0, 4'h6, 1'b0, 10);
    in_valid[0] = 1'b1;
    d_in[0] = 32'hDEAD_BEEF;
    tick();
    in_valid[0] = 1'b0;
    repeat (14) tick();
    check("busy_mid_calc", 64'(busy[0]), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle(0);
    repeat (40) tick();
    check_idle(0);
    xact(0, 32'h0000_0001, 1'b0, 4'h0, 4'h3, 1'b0, 0);
    for (int k = 1; k < 3; k++) begin
      xact(k, 32'h0000_0001, 1'b0, 4'h0, 4'h3, 1'b0, 0);
      xact(k, 32'hFFFF_FFFF, 1'b0, 4'h0, 4'h5, 1'b0, 0);
      xact(k, 32'h8000_0000, 1'b1, 4'h7, 4'h6, 1'b1, 3);
    end
    for (int n = 0; n < 1000; n++) begin
      int k, stall;
      logic [31:0] d;
      logic c;
      logic [3:0] ci;
      k = int'($urandom_range(0, 2));
      d = $urandom;
      c = 1'($urandom_range(0, 1));
      ci = $urandom_range(0, 1) == 1 ? crc_ref(d) : 4'($urandom);
      stall = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 5)) : 0;
      xact(k, d, c, ci, crc_ref(d), c && (ci != crc_ref(d)), stall);
    end
    check("sb_leftover", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
